// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//
// Age-ordered issue queue in front of a single ALU. Dispatched instructions
// wait here until both source operands are present. Each cycle the oldest
// ready entry is issued into a registered 160-bit packet. The remaining
// entries then slide toward index 0, so the order of the entries always
// matches their age.
//
// Optional feature macro: ALU_IQ_WAKEUP_BYPASS_EN
//   defined   : an operand woken by this cycle's writeback counts as ready
//               for selection in the same cycle, and wb_data is forwarded
//               into the packet (wakeup-to-issue 1 cycle).
//   undefined : selection looks only at registered ready bits
//               (wakeup-to-issue 2 cycles).
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   flush               : drop every queued entry and any pending issue
//   disp_valid/_ready   : dispatch handshake; ready while occupancy < DEPTH
//   disp_rs1/rs2(_rdy/_tag) : operand value, presence flag, awaited producer itag
//   disp_rd_idex, disp_imm, disp_op_type, disp_op, disp_itag : carried to issue
//   wb_valid/itag/data  : result broadcast used for operand wakeup
//   alu_en, alu_data    : registered issue packet
//                         {rs1, rs2, rd_idex, imm, op_type, op, itag}
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         disp_valid,
  output logic         disp_ready,
  input  logic [63:0]  disp_rs1,
  input  logic [63:0]  disp_rs2,
  input  logic         disp_rs1_rdy,
  input  logic         disp_rs2_rdy,
  input  logic [4:0]   disp_rs1_tag,
  input  logic [4:0]   disp_rs2_tag,
  input  logic [4:0]   disp_rd_idex,
  input  logic [11:0]  disp_imm,
  input  logic [4:0]   disp_op_type,
  input  logic [4:0]   disp_op,
  input  logic [4:0]   disp_itag,
  input  logic         wb_valid,
  input  logic [4:0]   wb_itag,
  input  logic [63:0]  wb_data,
  output logic         alu_en,
  output logic [159:0] alu_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // Entry storage; meta holds {rd_idex, imm, op_type, op, itag}.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [63:0]      rs1_q [DEPTH];
  logic [63:0]      rs1_d [DEPTH];
  logic [63:0]      rs2_q [DEPTH];
  logic [63:0]      rs2_d [DEPTH];
  logic [4:0]       rs1_tag_q [DEPTH];
  logic [4:0]       rs1_tag_d [DEPTH];
  logic [4:0]       rs2_tag_q [DEPTH];
  logic [4:0]       rs2_tag_d [DEPTH];
  logic [31:0]      meta_q [DEPTH];
  logic [31:0]      meta_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             alu_en_q, alu_en_d;
  logic [159:0]     alu_data_q, alu_data_d;

  // Entries as seen after this cycle's writeback has been applied.
  logic [DEPTH-1:0] wk_rs1_rdy_s, wk_rs2_rdy_s, elig_s;
  logic [63:0]      wk_rs1_s [DEPTH];
  logic [63:0]      wk_rs2_s [DEPTH];

  logic             sel_found_s;
  logic [IW-1:0]    sel_idx_s;
  logic [CW-1:0]    count_rem_s;
  logic             accept_s;
  logic             d_rs1_rdy_s, d_rs2_rdy_s;
  logic [63:0]      d_rs1_s, d_rs2_s;

  assign disp_ready = (count_q < CW'(DEPTH));
  assign accept_s   = disp_valid & disp_ready & ~flush;
  assign alu_en     = alu_en_q;
  assign alu_data   = alu_data_q;

  // Apply the writeback broadcast to queued operands still waiting on a tag.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rs1_rdy_q[i] && wb_valid && (rs1_tag_q[i] == wb_itag)) begin
        wk_rs1_rdy_s[i] = 1'b1;
        wk_rs1_s[i]     = wb_data;
      end else begin
        wk_rs1_rdy_s[i] = rs1_rdy_q[i];
        wk_rs1_s[i]     = rs1_q[i];
      end
      if (valid_q[i] && !rs2_rdy_q[i] && wb_valid && (rs2_tag_q[i] == wb_itag)) begin
        wk_rs2_rdy_s[i] = 1'b1;
        wk_rs2_s[i]     = wb_data;
      end else begin
        wk_rs2_rdy_s[i] = rs2_rdy_q[i];
        wk_rs2_s[i]     = rs2_q[i];
      end
    end
  end

  // Apply the same writeback to the instruction being dispatched this cycle.
  always_comb begin
    if (!disp_rs1_rdy && wb_valid && (disp_rs1_tag == wb_itag)) begin
      d_rs1_rdy_s = 1'b1;
      d_rs1_s     = wb_data;
    end else begin
      d_rs1_rdy_s = disp_rs1_rdy;
      d_rs1_s     = disp_rs1;
    end
    if (!disp_rs2_rdy && wb_valid && (disp_rs2_tag == wb_itag)) begin
      d_rs2_rdy_s = 1'b1;
      d_rs2_s     = wb_data;
    end else begin
      d_rs2_rdy_s = disp_rs2_rdy;
      d_rs2_s     = disp_rs2;
    end
  end

`ifdef ALU_IQ_WAKEUP_BYPASS_EN
  // A same-cycle wakeup already makes the operand eligible.
  assign elig_s = valid_q & wk_rs1_rdy_s & wk_rs2_rdy_s;
`else
  // Only operands that were ready at the start of the cycle are eligible.
  assign elig_s = valid_q & rs1_rdy_q & rs2_rdy_q;
`endif

  // Oldest-first pick: scanning downward leaves the lowest eligible index.
  always_comb begin
    sel_idx_s = {IW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s = elig_s[i] ? IW'(i) : sel_idx_s;
    end
    sel_found_s = |elig_s;
  end

  // Compact around the issued slot, then append any accepted dispatch.
  always_comb begin
    int src_idx;
    src_idx     = 0;
    count_rem_s = count_q - {{(CW-1){1'b0}}, sel_found_s};
    count_d     = count_rem_s + {{(CW-1){1'b0}}, accept_s};
    for (int i = 0; i < DEPTH; i++) begin
      // Entries at or above the issued slot shift down by one.
      if (sel_found_s && (i >= int'(sel_idx_s)) && (i < DEPTH - 1)) begin
        src_idx = i + 1;
      end else begin
        src_idx = i;
      end
      if (accept_s && (i == int'(count_rem_s))) begin
        rs1_d[i]     = d_rs1_s;
        rs2_d[i]     = d_rs2_s;
        rs1_rdy_d[i] = d_rs1_rdy_s;
        rs2_rdy_d[i] = d_rs2_rdy_s;
        rs1_tag_d[i] = disp_rs1_tag;
        rs2_tag_d[i] = disp_rs2_tag;
        meta_d[i]    = {disp_rd_idex, disp_imm, disp_op_type, disp_op, disp_itag};
      end else begin
        rs1_d[i]     = wk_rs1_s[src_idx];
        rs2_d[i]     = wk_rs2_s[src_idx];
        rs1_rdy_d[i] = wk_rs1_rdy_s[src_idx];
        rs2_rdy_d[i] = wk_rs2_rdy_s[src_idx];
        rs1_tag_d[i] = rs1_tag_q[src_idx];
        rs2_tag_d[i] = rs2_tag_q[src_idx];
        meta_d[i]    = meta_q[src_idx];
      end
      // Live entries are always packed at the bottom of the array.
      valid_d[i] = (i < int'(count_d));
    end
    if (flush) begin
      count_d = {CW{1'b0}};
      valid_d = {DEPTH{1'b0}};
    end else begin
      count_d = count_d;
      valid_d = valid_d;
    end
  end

  // Build the issue packet; the payload holds its value when nothing issues.
  always_comb begin
    if (flush) begin
      alu_en_d   = 1'b0;
      alu_data_d = alu_data_q;
    end else if (sel_found_s) begin
      alu_en_d   = 1'b1;
      alu_data_d = {wk_rs1_s[sel_idx_s], wk_rs2_s[sel_idx_s], meta_q[sel_idx_s]};
    end else begin
      alu_en_d   = 1'b0;
      alu_data_d = alu_data_q;
    end
  end

  // Queue, occupancy and issue registers; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= {DEPTH{1'b0}};
      rs1_rdy_q  <= {DEPTH{1'b0}};
      rs2_rdy_q  <= {DEPTH{1'b0}};
      count_q    <= {CW{1'b0}};
      alu_en_q   <= 1'b0;
      alu_data_q <= 160'd0;
    end else begin
      valid_q    <= valid_d;
      rs1_rdy_q  <= rs1_rdy_d;
      rs2_rdy_q  <= rs2_rdy_d;
      count_q    <= count_d;
      alu_en_q   <= alu_en_d;
      alu_data_q <= alu_data_d;
    end
  end

  // Operand payloads and tags need no reset: valid bits gate their use.
  always_ff @(posedge clk) begin
    rs1_q     <= rs1_d;
    rs2_q     <= rs2_d;
    rs1_tag_q <= rs1_tag_d;
    rs2_tag_q <= rs2_tag_d;
    meta_q    <= meta_d;
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue (DEPTH = 4).
// A queue-of-records model predicts alu_en, alu_data and disp_ready after
// every clock edge. Hand-computed literals pin the directed scenarios.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
`ifdef ALU_IQ_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         flush;
  logic         disp_valid;
  logic         disp_ready;
  logic [63:0]  disp_rs1;
  logic [63:0]  disp_rs2;
  logic         disp_rs1_rdy;
  logic         disp_rs2_rdy;
  logic [4:0]   disp_rs1_tag;
  logic [4:0]   disp_rs2_tag;
  logic [4:0]   disp_rd_idex;
  logic [11:0]  disp_imm;
  logic [4:0]   disp_op_type;
  logic [4:0]   disp_op;
  logic [4:0]   disp_itag;
  logic         wb_valid;
  logic [4:0]   wb_itag;
  logic [63:0]  wb_data;
  logic         alu_en;
  logic [159:0] alu_data;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rd_idex(disp_rd_idex), .disp_imm(disp_imm),
    .disp_op_type(disp_op_type), .disp_op(disp_op), .disp_itag(disp_itag),
    .wb_valid(wb_valid), .wb_itag(wb_itag), .wb_data(wb_data),
    .alu_en(alu_en), .alu_data(alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        r1;
    logic        r2;
    logic [4:0]  t1;
    logic [4:0]  t2;
    logic [31:0] meta;
  } ent_t;

  ent_t         mq[$];
  logic         exp_en;
  logic [159:0] exp_data;
  logic         exp_rdy;
  int           checks;
  int           errors;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pending writeback applied to one operand record.
  function automatic ent_t wake(input ent_t e);
    ent_t r;
    r = e;
    if (wb_valid && !r.r1 && (r.t1 == wb_itag)) begin
      r.r1 = 1'b1;
      r.rs1 = wb_data;
    end
    if (wb_valid && !r.r2 && (r.t2 == wb_itag)) begin
      r.r2 = 1'b1;
      r.rs2 = wb_data;
    end
    return r;
  endfunction

  // What the queue must look like after this edge, from the inputs seen now.
  task automatic model_update();
    int   sel;
    logic acc;
    logic r1;
    logic r2;
    ent_t e;
    if (rst) begin
      mq.delete();
      exp_en   = 1'b0;
      exp_data = '0;
    end else if (flush) begin
      mq.delete();
      exp_en = 1'b0;
    end else begin
      acc = disp_valid && (mq.size() < DEPTH);
      sel = -1;
      foreach (mq[i]) begin
        r1 = mq[i].r1 || (BYP && wb_valid && (mq[i].t1 == wb_itag));
        r2 = mq[i].r2 || (BYP && wb_valid && (mq[i].t2 == wb_itag));
        if (sel < 0 && r1 && r2) sel = i;
      end
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (sel >= 0) begin
        exp_en   = 1'b1;
        exp_data = {mq[sel].rs1, mq[sel].rs2, mq[sel].meta};
        mq.delete(sel);
      end else begin
        exp_en = 1'b0;
      end
      if (acc) begin
        e.rs1  = disp_rs1;
        e.rs2  = disp_rs2;
        e.r1   = disp_rs1_rdy;
        e.r2   = disp_rs2_rdy;
        e.t1   = disp_rs1_tag;
        e.t2   = disp_rs2_tag;
        e.meta = {disp_rd_idex, disp_imm, disp_op_type, disp_op, disp_itag};
        mq.push_back(wake(e));
      end
    end
    exp_rdy = (mq.size() < DEPTH);
  endtask

  // One clock: model advances at the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("alu_en", {159'd0, alu_en}, {159'd0, exp_en});
    check("alu_data", alu_data, exp_data);
    check("disp_ready", {159'd0, disp_ready}, {159'd0, exp_rdy});
  endtask

  task automatic set_disp(input logic v, input logic [63:0] a, input logic ar, input logic [4:0] at,
                          input logic [63:0] b, input logic br, input logic [4:0] bt, input logic [4:0] it);
    disp_valid   = v;
    disp_rs1     = a;
    disp_rs1_rdy = ar;
    disp_rs1_tag = at;
    disp_rs2     = b;
    disp_rs2_rdy = br;
    disp_rs2_tag = bt;
    disp_itag    = it;
    disp_rd_idex = it ^ 5'h1f;
    disp_imm     = 12'h100 + {7'd0, it};
    disp_op_type = 5'h2;
    disp_op      = 5'h1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] t, input logic [63:0] d);
    wb_valid = v;
    wb_itag  = t;
    wb_data  = d;
  endtask

  logic         en1;
  logic         en2;
  logic [159:0] data1;
  logic [159:0] data2;
  logic [159:0] a_pkt;

  initial begin
    checks   = 0;
    errors   = 0;
    exp_en   = 1'b0;
    exp_data = '0;
    exp_rdy  = 1'b1;
    rst   = 1'b1;
    flush = 1'b0;
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 64'd0);

    // Reset state
    step();
    step();
    check("rst_en", {159'd0, alu_en}, 160'd0);
    check("rst_data", alu_data, 160'd0);
    check("rst_ready", {159'd0, disp_ready}, 160'd1);
    rst = 1'b0;
    step();

    // Both-ready dispatch issues on the following edge
    set_disp(1'b1, 64'd5, 1'b1, 5'd0, 64'd7, 1'b1, 5'd0, 5'd3);
    step();
    check("r030_no_issue_yet", {159'd0, alu_en}, 160'd0);
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step();
    check("r030_en", {159'd0, alu_en}, 160'd1);
    check("r030_rs1", {96'd0, alu_data[159:96]}, 160'd5);
    check("r030_rs2", {96'd0, alu_data[95:32]}, 160'd7);
    check("r030_itag", {155'd0, alu_data[4:0]}, 160'd3);
    check("r030_op", {155'd0, alu_data[9:5]}, 160'd1);
    step();
    check("r020_idle_en", {159'd0, alu_en}, 160'd0);
    check("r020_hold_rs1", {96'd0, alu_data[159:96]}, 160'd5);

    // Younger ready entry overtakes an older waiting one
    set_disp(1'b1, 64'h11, 1'b1, 5'd0, 64'hbad, 1'b0, 5'd9, 5'd1);
    step();
    set_disp(1'b1, 64'h22, 1'b1, 5'd0, 64'h33, 1'b1, 5'd0, 5'd2);
    step();
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step();
    check("r031_b_first", {155'd0, alu_data[4:0]}, 160'd2);
    check("r031_b_en", {159'd0, alu_en}, 160'd1);
    set_wb(1'b1, 5'd9, 64'h10);
    step();
    en1   = alu_en;
    data1 = alu_data;
    set_wb(1'b0, 5'd0, 64'd0);
    step();
    en2   = alu_en;
    data2 = alu_data;
    check("r031_latency1", {159'd0, en1}, {159'd0, BYP});
    check("r031_latency2", {159'd0, en2}, {159'd0, ~BYP});
    a_pkt = en1 ? data1 : data2;
    check("r031_a_rs2", {96'd0, a_pkt[95:32]}, 160'h10);
    check("r031_a_rs1", {96'd0, a_pkt[159:96]}, 160'h11);
    check("r031_a_itag", {155'd0, a_pkt[4:0]}, 160'd1);

    // Fill with waiting entries; extra dispatch ignored
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, 64'hdead, 1'b0, 5'(20 + k), 64'h1000 + 64'(k), 1'b1, 5'd0, 5'(10 + k));
      step();
    end
    check("r032_full", {159'd0, disp_ready}, 160'd0);
    set_disp(1'b1, 64'h44, 1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 5'd30);
    step();
    check("r032_ignored_en", {159'd0, alu_en}, 160'd0);
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    set_wb(1'b1, 5'd20, 64'h77);
    step();
    set_wb(1'b0, 5'd0, 64'd0);
    step();
    check("r032_ready_again", {159'd0, disp_ready}, 160'd1);
    step();

    // Full queue: issue and dispatch in the same cycle, dispatch rejected
    set_disp(1'b1, 64'h5a, 1'b1, 5'd0, 64'h5b, 1'b1, 5'd0, 5'd15);
    step();
    check("r033_full", {159'd0, disp_ready}, 160'd0);
    set_disp(1'b1, 64'h6a, 1'b1, 5'd0, 64'h6b, 1'b1, 5'd0, 5'd16);
    step();
    check("r033_issue", {155'd0, alu_data[4:0]}, 160'd15);
    check("r033_occ3", {159'd0, disp_ready}, 160'd1);
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step();
    check("r033_dropped", {159'd0, alu_en}, 160'd0);

    // Flush outranks dispatch
    flush = 1'b1;
    set_disp(1'b1, 64'h7a, 1'b1, 5'd0, 64'h7b, 1'b1, 5'd0, 5'd17);
    step();
    check("r034_en", {159'd0, alu_en}, 160'd0);
    check("r034_ready", {159'd0, disp_ready}, 160'd1);
    flush = 1'b0;
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step();
    check("r034_dropped", {159'd0, alu_en}, 160'd0);
    set_wb(1'b1, 5'd21, 64'h1);
    step();
    set_wb(1'b0, 5'd0, 64'd0);
    step();
    check("r034_empty", {159'd0, alu_en}, 160'd0);

    // Reset mid-operation beats wakeup and dispatch
    set_disp(1'b1, 64'h81, 1'b1, 5'd0, 64'd0, 1'b0, 5'd5, 5'd7);
    step();
    set_disp(1'b1, 64'h82, 1'b1, 5'd0, 64'd0, 1'b0, 5'd6, 5'd8);
    step();
    rst = 1'b1;
    set_wb(1'b1, 5'd5, 64'h99);
    set_disp(1'b1, 64'h83, 1'b1, 5'd0, 64'h84, 1'b1, 5'd0, 5'd18);
    step();
    check("r035_en", {159'd0, alu_en}, 160'd0);
    check("r035_data", alu_data, 160'd0);
    rst = 1'b0;
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    set_wb(1'b1, 5'd6, 64'h98);
    step();
    check("r035_quiet1", {159'd0, alu_en}, 160'd0);
    set_wb(1'b1, 5'd5, 64'h97);
    step();
    check("r035_quiet2", {159'd0, alu_en}, 160'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    set_disp(1'b1, 64'h123, 1'b1, 5'd0, 64'h456, 1'b1, 5'd0, 5'd19);
    step();
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    step();
    check("r035_new_issue", {159'd0, alu_en}, 160'd1);
    check("r035_new_rs1", {96'd0, alu_data[159:96]}, 160'h123);

    // One tag feeds both operands, and a dispatch-cycle wakeup
    set_disp(1'b1, 64'd0, 1'b0, 5'd12, 64'd0, 1'b0, 5'd12, 5'd20);
    step();
    set_disp(1'b1, 64'd0, 1'b0, 5'd12, 64'h9, 1'b1, 5'd0, 5'd21);
    set_wb(1'b1, 5'd12, 64'habc);
    step();
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    for (int k = 0; k < 3; k++) step();

    // Back-to-back ready dispatches with continuous issue
    for (int k = 0; k < 5; k++) begin
      set_disp(1'b1, 64'h200 + 64'(k), 1'b1, 5'd0, 64'h300 + 64'(k), 1'b1, 5'd0, 5'(k + 24));
      step();
    end
    set_disp(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    for (int k = 0; k < 3; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
